wtb_fifo: RTL and testbench
===========================

Name: wtb_fifo

Overview:
- Write-through buffer placed between the cache front-end write path and the back-end write channel.
- Queues word writes: address, data and byte strobes.
- Presents the oldest queued entry to the back-end through a valid/ready handshake.
- Reports empty/level so the cache controller can hold read-miss line replacement until all queued writes have drained.
- Write-through policy only; one entry is one FE word.

Parameters:
- FE_ADDR_W, 32, front-end byte-address width
- FE_DATA_W, 32, word width
- FE_NBYTES, FE_DATA_W/8, bytes per word
- FE_BYTE_W, $clog2(FE_NBYTES), byte-offset bits discarded from address
- DEPTH_W, 2, log2 of entry count (depth = 2**DEPTH_W, minimum 1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- push_valid  input  1  front-end write request
- push_addr  input  [FE_ADDR_W-1:FE_BYTE_W]  word address
- push_wdata  input  FE_DATA_W  write data
- push_wstrb  input  FE_NBYTES  byte strobes
- push_ready  output  1  entry accepted this cycle when high with push_valid
- empty  output  1  no entries queued
- full  output  1  all entries occupied
- level  output  DEPTH_W+1  occupied entry count
- write_valid  output  1  head entry valid toward back-end
- write_addr  output  [FE_ADDR_W-1:FE_BYTE_W]  head address
- write_wdata  output  FE_DATA_W  head data
- write_wstrb  output  FE_NBYTES  head strobes
- write_ready  input  1  back-end completion pulse; head consumed

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and level = 0; empty=1, full=0, push_ready=1, write_valid=0.
  - write_addr/wdata/wstrb read as 0 while empty.
  - Storage contents need no reset.
- Combinational flags: push_ready = !full; write_valid = !empty; empty = (level==0); full = (level==2**DEPTH_W).
- Push: on rising edge with push_valid && push_ready, write entry at tail pointer and increment tail (DEPTH_W bits, natural wrap).
- Push while full: ignored and not stored. The front-end must hold the request until push_ready.
- Pop: on rising edge with write_valid && write_ready, increment head pointer (natural wrap).
- write_ready while empty is ignored; no state change.
- Head stability: while write_valid is high and write_ready has not arrived, write_addr/wdata/wstrb stay constant. The back-end latches or re-samples the head freely across a multi-cycle AXI burst.
- Latency: push into an empty buffer gives write_valid=1 on the next cycle, with the pushed values.
- Simultaneous push and pop:
  - Both happen; level unchanged.
  - When level==1, the popped head is replaced by the new entry next cycle.
  - When full: push_ready=0, so only the pop happens and level decrements.
- Ordering: strict FIFO; no reordering or bypass except the optional merge.
- Level arithmetic: level +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds 2**DEPTH_W or goes below 0.
- Reset mid-operation: all queued entries discarded immediately. The back-end must also be reset; no completion is expected afterwards.

Optional Feature:
- Macro: WTB_COALESCE_EN.
- Defined: a push whose push_addr equals the address of the most recent (tail-1) entry merges into that entry instead of allocating. Merge conditions:
  - That entry is not the head, i.e. level>=2, counting a pop in the same cycle as not yet removed.
  - Bytes with push_wstrb=1 overwrite; stored wstrb becomes stored|push_wstrb.
  - Level and tail unchanged.
  - push_ready stays high for a merging push even when full.
- Undefined: every accepted push allocates a new entry; full blocks all pushes.

Test Plan:
- Reset then single push (addr 0x0000_1000>>2, data 0xDEADBEEF, strb 0xF) -> next cycle write_valid=1, write_addr=0x400, level=1; write_ready pulse -> empty=1 next cycle.
- Push 4 distinct entries with write_ready low (DEPTH_W=2) -> full=1, push_ready=0; 5th push held -> not stored; drain 4 pulses -> outputs in push order, then empty.
- Head hold: push A then B, keep write_ready low 20 cycles -> write_addr/wdata constant = A every cycle.
- Simultaneous push/pop at level=1 and at full -> level stays 1; level goes 4->3; no entry lost or duplicated; 200-op random scoreboard matches.
- Assert reset mid-drain with level=3 -> same cycle write_valid=0, level=0; the first post-reset push appears unaltered.
- WTB_COALESCE_EN defined: push A(addr 0x10, 0x11223344, 0xF), B(addr 0x20, 0xAAAAAAAA, 0xF), C(addr 0x20, 0x000000BB, 0x1) -> level=2; second entry data 0xAAAAAABB, strb 0xF. Same sequence with the macro undefined -> level=3.

Source files
------------

// File: rtl/wtb_fifo_if.sv
// ---------------------------------------------------------------------------
// wtb_fifo_if: signal bundle for the write-through buffer.
//
// Groups the front-end push channel, the occupancy flags and the back-end
// write channel of wtb_fifo.
//   slave  modport : buffer side (consumes pushes, produces the head entry)
//   master modport : environment side (front-end + back-end)
//
// Signals
//   push_valid/addr/wdata/wstrb : front-end word write request
//   push_ready                  : request accepted this cycle
//   empty/full/level            : occupancy status
//   write_valid/addr/wdata/wstrb: oldest queued entry toward the back-end
//   write_ready                 : back-end completion pulse, consumes head
// ---------------------------------------------------------------------------
interface wtb_fifo_if #(
   parameter int unsigned FE_ADDR_W = 32,
   parameter int unsigned FE_DATA_W = 32,
   parameter int unsigned FE_NBYTES = FE_DATA_W / 8,
   parameter int unsigned FE_BYTE_W = $clog2(FE_NBYTES),
   parameter int unsigned DEPTH_W   = 2
);

   logic                          push_valid;
   logic [FE_ADDR_W-1:FE_BYTE_W]  push_addr;
   logic [FE_DATA_W-1:0]          push_wdata;
   logic [FE_NBYTES-1:0]          push_wstrb;
   logic                          push_ready;

   logic                          empty;
   logic                          full;
   logic [DEPTH_W:0]              level;

   logic                          write_valid;
   logic [FE_ADDR_W-1:FE_BYTE_W]  write_addr;
   logic [FE_DATA_W-1:0]          write_wdata;
   logic [FE_NBYTES-1:0]          write_wstrb;
   logic                          write_ready;

   modport slave (
      input  push_valid, push_addr, push_wdata, push_wstrb, write_ready,
      output push_ready, empty, full, level,
      output write_valid, write_addr, write_wdata, write_wstrb
   );

   modport master (
      output push_valid, push_addr, push_wdata, push_wstrb, write_ready,
      input  push_ready, empty, full, level,
      input  write_valid, write_addr, write_wdata, write_wstrb
   );

endinterface

// File: rtl/wtb_fifo.sv
// ---------------------------------------------------------------------------
// wtb_fifo: write-through buffer between the cache front-end write path and
// the back-end write channel.
//
// Queues word writes (address, data, byte strobes) and presents the oldest
// entry to the back-end with a valid/ready handshake. empty/level let the
// cache controller hold line replacement until all writes have drained.
//
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset (discards all queued entries)
//   bus   : wtb_fifo_if.slave (push channel, status flags, write channel)
//
// Optional feature (macro WTB_COALESCE_EN):
//   A push whose address matches the most recent entry merges into it,
//   provided that entry is not the head (level >= 2). Strobed bytes are
//   overwritten and strobes are OR-ed; level and tail are unchanged, and the
//   merging push is accepted even when full.
// ---------------------------------------------------------------------------
module wtb_fifo #(
   parameter int unsigned FE_ADDR_W = 32,
   parameter int unsigned FE_DATA_W = 32,
   parameter int unsigned FE_NBYTES = FE_DATA_W / 8,
   parameter int unsigned FE_BYTE_W = $clog2(FE_NBYTES),
   parameter int unsigned DEPTH_W   = 2
) (
   input  logic        clk,
   input  logic        reset,
   wtb_fifo_if.slave   bus
);

   localparam int unsigned DEPTH = 1 << DEPTH_W;
   // Keep at least one pointer bit so a single-entry buffer still elaborates.
   localparam int unsigned PTR_W = (DEPTH_W > 0) ? DEPTH_W : 1;
   localparam int unsigned LVL_W = DEPTH_W + 1;
   localparam int unsigned AW    = FE_ADDR_W - FE_BYTE_W;

   typedef logic [PTR_W-1:0] ptr_t;

   localparam ptr_t             PTR_LAST = ptr_t'(DEPTH - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [AW-1:0]        mem_addr [DEPTH];
   logic [FE_DATA_W-1:0] mem_data [DEPTH];
   logic [FE_NBYTES-1:0] mem_strb [DEPTH];

   ptr_t             head_q, head_d;
   ptr_t             tail_q, tail_d;
   logic [LVL_W-1:0] level_q, level_d;

   logic empty, full;
   logic do_push, do_alloc, do_merge, do_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

`ifdef WTB_COALESCE_EN
   ptr_t tail_prev;

   // level >= 2 uses the pre-pop level: an entry popped this cycle still
   // counts, so the merge target can never be the head being consumed.
   always_comb begin
      tail_prev = (tail_q == '0) ? PTR_LAST : tail_q - 1'b1;
      do_merge  = bus.push_valid && (32'(level_q) >= 32'd2) &&
                  (mem_addr[tail_prev] == bus.push_addr);
   end
`else
   assign do_merge = 1'b0;
`endif

   assign empty    = (level_q == '0);
   assign full     = (level_q == LVL_FULL);
   assign do_push  = bus.push_valid && bus.push_ready;
   assign do_alloc = do_push && !do_merge;
   assign do_pop   = !empty && bus.write_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      if (do_alloc) tail_d = ptr_inc(tail_q);
      if (do_pop)   head_d = ptr_inc(head_q);
      unique case ({do_alloc, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
      end
   end

   // Storage is not reset; only entries inside [head, tail) are ever read.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         mem_addr[tail_q] <= bus.push_addr;
         mem_data[tail_q] <= bus.push_wdata;
         mem_strb[tail_q] <= bus.push_wstrb;
      end
`ifdef WTB_COALESCE_EN
      else if (do_merge) begin
         for (int b = 0; b < int'(FE_NBYTES); b++) begin
            if (bus.push_wstrb[b]) mem_data[tail_prev][b*8 +: 8] <= bus.push_wdata[b*8 +: 8];
         end
         mem_strb[tail_prev] <= mem_strb[tail_prev] | bus.push_wstrb;
      end
`endif
   end

   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.level       = level_q;
   assign bus.push_ready  = !full || do_merge;
   assign bus.write_valid = !empty;
   assign bus.write_addr  = empty ? '0 : mem_addr[head_q];
   assign bus.write_wdata = empty ? '0 : mem_data[head_q];
   assign bus.write_wstrb = empty ? '0 : mem_strb[head_q];

endmodule

// File: tb/tb_wtb_fifo.sv
module tb_wtb_fifo;

   localparam int DEPTH_W = 2;
   localparam int DEPTH   = 1 << DEPTH_W;
`ifdef WTB_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   wtb_fifo_if #(.DEPTH_W(DEPTH_W)) bus ();

   wtb_fifo #(.DEPTH_W(DEPTH_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every status/head output against the reference queue.
   task automatic check_state();
      ent_t h;
      h.a = '0; h.d = '0; h.s = '0;
      if (q.size() > 0) h = q[0];
      chk("level", 64'(bus.level), 64'(q.size()));
      chk("empty", 64'(bus.empty), 64'(q.size() == 0));
      chk("full", 64'(bus.full), 64'(q.size() == DEPTH));
      chk("write_valid", 64'(bus.write_valid), 64'(q.size() != 0));
      chk("write_addr", 64'(bus.write_addr), 64'(h.a));
      chk("write_wdata", 64'(bus.write_wdata), 64'(h.d));
      chk("write_wstrb", 64'(bus.write_wstrb), 64'(h.s));
   endtask

   // One clock cycle: drive inputs, check push_ready, clock, update model, check.
   task automatic step(input logic pv, input logic [29:0] pa, input logic [31:0] pd,
                       input logic [3:0] ps, input logic wr);
      bit   merge, acc, pop;
      ent_t e;
      bus.push_valid  = pv;
      bus.push_addr   = pa;
      bus.push_wdata  = pd;
      bus.push_wstrb  = ps;
      bus.write_ready = wr;
      @(negedge clk);
      merge = COAL && pv && (q.size() >= 2) && (q[$].a == pa);
      chk("push_ready", 64'(bus.push_ready), 64'((q.size() < DEPTH) || merge));
      acc = pv && ((q.size() < DEPTH) || merge);
      pop = (q.size() > 0) && wr;
      @(posedge clk);
      #1;
      if (acc && merge) begin
         e = q[q.size()-1];
         for (int b = 0; b < 4; b++) if (ps[b]) e.d[b*8 +: 8] = pd[b*8 +: 8];
         e.s = e.s | ps;
         q[q.size()-1] = e;
      end
      if (pop) void'(q.pop_front());
      if (acc && !merge) begin
         e.a = pa; e.d = pd; e.s = ps;
         q.push_back(e);
      end
      check_state();
   endtask

   task automatic push(input logic [29:0] pa, input logic [31:0] pd, input logic [3:0] ps);
      step(1'b1, pa, pd, ps, 1'b0);
   endtask

   task automatic idle(input logic wr);
      step(1'b0, 30'h0, 32'h0, 4'h0, wr);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) idle(1'b1);
      chk("drain_empty", 64'(bus.empty), 64'd1);
   endtask

   initial begin
      bus.push_valid  = 1'b0;
      bus.push_addr   = '0;
      bus.push_wdata  = '0;
      bus.push_wstrb  = '0;
      bus.write_ready = 1'b0;
      #12;
      check_state();
      chk("reset_push_ready", 64'(bus.push_ready), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_state();

      // Single push, then completion pulse.
      push(30'(32'h0000_1000 >> 2), 32'hDEADBEEF, 4'hF);
      chk("single_addr", 64'(bus.write_addr), 64'h400);
      chk("single_valid", 64'(bus.write_valid), 64'd1);
      chk("single_level", 64'(bus.level), 64'd1);
      idle(1'b1);
      chk("single_empty", 64'(bus.empty), 64'd1);

      // Fill to full, held 5th push, push+pop at full, drain in order.
      for (int i = 0; i < DEPTH; i++) push(30'(32'h100 + i), 32'hA000_0000 + i, 4'hF);
      chk("fill_full", 64'(bus.full), 64'd1);
      chk("fill_push_ready", 64'(bus.push_ready), 64'd0);
      push(30'h200, 32'h5555_5555, 4'h3);
      push(30'h200, 32'h5555_5555, 4'h3);
      step(1'b1, 30'h200, 32'h5555_5555, 4'h3, 1'b1);
      chk("full_pushpop_level", 64'(bus.level), 64'd3);
      drain();

      // Push+pop at level 1: head is replaced by the new entry.
      push(30'h300, 32'h1111_1111, 4'hF);
      step(1'b1, 30'h301, 32'h2222_2222, 4'hC, 1'b1);
      chk("lvl1_level", 64'(bus.level), 64'd1);
      chk("lvl1_head", 64'(bus.write_wdata), 64'h2222_2222);
      drain();

      // Head hold for 20 cycles with back-end stalled.
      push(30'h0AA, 32'hCAFE_F00D, 4'hF);
      push(30'h0BB, 32'h0BAD_0BAD, 4'hF);
      for (int i = 0; i < 20; i++) begin
         idle(1'b0);
         chk("hold_addr", 64'(bus.write_addr), 64'h0AA);
         chk("hold_data", 64'(bus.write_wdata), 64'hCAFE_F00D);
      end
      drain();

      // Coalescing sequence.
      push(30'h10, 32'h1122_3344, 4'hF);
      push(30'h20, 32'hAAAA_AAAA, 4'hF);
      push(30'h20, 32'h0000_00BB, 4'h1);
`ifdef WTB_COALESCE_EN
      chk("coal_level", 64'(bus.level), 64'd2);
      idle(1'b1);
      chk("coal_data", 64'(bus.write_wdata), 64'hAAAA_AABB);
      chk("coal_strb", 64'(bus.write_wstrb), 64'hF);
`else
      chk("coal_level", 64'(bus.level), 64'd3);
`endif
      drain();

      // Reset mid-drain at level 3.
      for (int i = 0; i < DEPTH; i++) push(30'(32'h700 + i), 32'hB000_0000 + i, 4'hF);
      idle(1'b1);
      chk("pre_reset_level", 64'(bus.level), 64'd3);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_write_valid", 64'(bus.write_valid), 64'd0);
      chk("rst_level", 64'(bus.level), 64'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_state();
      push(30'h3C0, 32'h7654_3210, 4'h6);
      chk("post_rst_addr", 64'(bus.write_addr), 64'h3C0);
      chk("post_rst_data", 64'(bus.write_wdata), 64'h7654_3210);
      chk("post_rst_strb", 64'(bus.write_wstrb), 64'h6);
      drain();

      // Random traffic against the reference queue.
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)), 30'($urandom_range(0, 3)), $urandom,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
